inv_mix_columns_seq: RTL and testbench
======================================

# inv_mix_columns_seq

Iterative AES InvMixColumns unit for the decryption datapath: accepts a 128-bit state over a valid/ready handshake, transforms one 32-bit column per clock using the inverse GF(2^8) matrix {0e,0b,0d,09}, and returns the full block over a second handshake. It is the decrypt-side counterpart of the combinational MixColumns stage. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse round.

## Interface
- No parameters; widths are fixed by AES (128-bit block, 32-bit column, 8-bit byte).
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream block present.
- i_ready  output  1  unit can accept; high only in IDLE.
- i_block  input  128  state; column w0 = [127:96] … w3 = [31:0]; byte b0 of each column is its MSB.
- o_valid  output  1  o_block holds a finished result.
- o_ready  input  1  downstream accepts result.
- o_block  output  128  transformed state, same layout as i_block.
- i_inverse  input  1  present only with `INV_MIX_FWD_EN` (see Configuration).

## Operation
- States:
  - IDLE: i_ready=1.
  - BUSY: col counter 0..3.
  - DONE: o_valid=1.
- IDLE → BUSY on i_valid && i_ready. Capture i_block into the working register; col=0.
- BUSY: each cycle, replace column w[col] (col 0 = [127:96]) with InvMixW(w[col]); col increments. After col=3, go to DONE. col wraps to 0.
- DONE: hold o_block/o_valid stable until o_ready. On o_valid && o_ready, go to IDLE.
- InvMixW(b0,b1,b2,b3):
  - mb0 = 0e·b0 ^ 0b·b1 ^ 0d·b2 ^ 09·b3
  - mb1 = 09·b0 ^ 0e·b1 ^ 0b·b2 ^ 0d·b3
  - mb2 = 0d·b0 ^ 09·b1 ^ 0e·b2 ^ 0b·b3
  - mb3 = 0b·b0 ^ 0d·b1 ^ 09·b2 ^ 0e·b3
- Multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1. xtime(a) = {a[6:0],0} ^ (8'h1b & {8{a[7]}}); higher coefficients are composed from xtime chains. All arithmetic is 8-bit with no carries.
- i_block and i_valid are ignored outside IDLE. o_ready is ignored outside DONE.
- o_block changes only in BUSY and on capture. Intermediate values are visible while o_valid=0; consumers must not sample them.

## Timing
- Reset values:
  - state=IDLE, col=0.
  - i_ready=1, o_valid=0, o_block=128'h0.
- Accept edge E0 → columns written at E1..E4 → o_valid=1 after E4. Latency is 4 cycles from accept to o_valid.
- Result handshake at edge Ek: o_valid falls and i_ready rises after Ek. The next accept can occur at Ek+1 at the earliest. There is no same-cycle turnaround.
- Throughput: 1 block per 6 cycles with o_ready tied high.
- Reset asserted in any state, including mid-BUSY or DONE with o_ready high: reset wins. The in-flight block is discarded and all outputs take their reset values on the next edge.
- i_valid held high during BUSY/DONE: no effect. The block is taken only when i_ready=1.

## Configuration
- `INV_MIX_FWD_EN` defined:
  - Adds the i_inverse port, sampled with i_block at accept.
  - 1 selects the inverse matrix; 0 selects the forward MixColumns matrix (02,03,01,01 rotations).
  - Timing and handshake are unchanged.
- Undefined: the port is absent and the unit is inverse-only.

## Structure
- Shared package `aes_pkg`:
  - xtime function.
  - Inverse coefficients 8'h0e/8'h0b/8'h0d/8'h09 and forward coefficients 8'h02/8'h03.
  - FSM state encoding (IDLE/BUSY/DONE).
- Sub-module `inv_mix_word`: combinational 32-bit column transform, instantiated once and muxed by col. With `INV_MIX_FWD_EN` it takes a mode input.

## Test plan
- FIPS-197 single column: i_block = {8e4da1bc, 9fdc589d, 01010101, c6c6c6c6} → o_block = {db135345, f20a225c, 01010101, c6c6c6c6}. o_valid rises exactly 4 cycles after accept.
- Second vector: columns {4d7ebdf8, d5d5d7d6, …} → {2d26314c, d4d4d4d5, …}. Round-trip 64 random blocks against a software forward MixColumns model; output must equal the original.
- Backpressure: hold o_ready=0 for 10 cycles in DONE. o_block and o_valid stay stable and i_ready stays 0. Releasing o_ready gives i_ready=1 on the next cycle.
- Reset mid-operation: assert reset at E2 of BUSY. Next cycle o_valid=0, o_block=0, i_ready=1. A fresh block then completes correctly.
- Input ignored while busy: change i_block/i_valid during BUSY. The result reflects only the captured block.
- With `INV_MIX_FWD_EN`: i_inverse=0, column db135345 → 8e4da1bc; i_inverse=1 on that result restores db135345.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, MixColumns coefficients and the column-FSM encoding.
package aes_pkg;

   localparam logic [7:0] INV_COEF_0E = 8'h0e;
   localparam logic [7:0] INV_COEF_0B = 8'h0b;
   localparam logic [7:0] INV_COEF_0D = 8'h0d;
   localparam logic [7:0] INV_COEF_09 = 8'h09;
   localparam logic [7:0] FWD_COEF_02 = 8'h02;
   localparam logic [7:0] FWD_COEF_03 = 8'h03;
   localparam logic [7:0] FWD_COEF_01 = 8'h01;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
   endfunction

   // Shift-and-add multiply built from an xtime chain, one term per coefficient bit.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) r = r ^ p;
         p = xtime(p);
      end
      return r;
   endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational single-column (Inv)MixColumns; with INV_MIX_FWD_EN a mode input picks the matrix.
module inv_mix_word
   import aes_pkg::*;
(
`ifdef INV_MIX_FWD_EN
   input  logic        inverse,
`endif
   input  logic [31:0] word_in,
   output logic [31:0] word_out
);

   logic [7:0] coef [4];
   logic [7:0] b    [4];
   logic [7:0] acc;
   logic [1:0] idx;

   // Row r uses the first-row coefficients rotated right by r, so the weight of byte c is coef[c-r].
   always_comb begin
      coef[0] = INV_COEF_0E;
      coef[1] = INV_COEF_0B;
      coef[2] = INV_COEF_0D;
      coef[3] = INV_COEF_09;
`ifdef INV_MIX_FWD_EN
      if (!inverse) begin
         coef[0] = FWD_COEF_02;
         coef[1] = FWD_COEF_03;
         coef[2] = FWD_COEF_01;
         coef[3] = FWD_COEF_01;
      end
`endif
      b[0] = word_in[31:24];
      b[1] = word_in[23:16];
      b[2] = word_in[15:8];
      b[3] = word_in[7:0];
      acc      = '0;
      idx      = '0;
      word_out = '0;
      for (int r = 0; r < 4; r++) begin
         acc = '0;
         for (int c = 0; c < 4; c++) begin
            idx = 2'(c - r);
            acc = acc ^ gf_mul(b[c], coef[idx]);
         end
         word_out = {word_out[23:0], acc};
      end
   end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one column per clock over valid/ready handshakes.
// Optional macro INV_MIX_FWD_EN adds i_inverse to select the forward matrix per block.
module inv_mix_columns_seq
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [127:0] i_block,
   output logic         o_valid,
   input  logic         o_ready,
   output logic [127:0] o_block
`ifdef INV_MIX_FWD_EN
   ,
   input  logic         i_inverse
`endif
);

   state_t       state;
   logic [1:0]   col;
   logic [31:0]  cur_word;
   logic [31:0]  mix_word;
   logic [127:0] next_block;
`ifdef INV_MIX_FWD_EN
   logic         mode;
`endif

   // o_block doubles as the working register; col selects the column rewritten this cycle.
   always_comb begin
      cur_word   = '0;
      next_block = o_block;
      case (col)
         2'd0: begin cur_word = o_block[127:96]; next_block[127:96] = mix_word; end
         2'd1: begin cur_word = o_block[95:64];  next_block[95:64]  = mix_word; end
         2'd2: begin cur_word = o_block[63:32];  next_block[63:32]  = mix_word; end
         default: begin cur_word = o_block[31:0]; next_block[31:0] = mix_word; end
      endcase
   end

   inv_mix_word u_word (
`ifdef INV_MIX_FWD_EN
      .inverse  (mode),
`endif
      .word_in  (cur_word),
      .word_out (mix_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         col     <= '0;
         o_block <= '0;
         i_ready <= 1'b1;
         o_valid <= 1'b0;
`ifdef INV_MIX_FWD_EN
         mode    <= 1'b1;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_valid && i_ready) begin
                  o_block <= i_block;
                  col     <= '0;
                  i_ready <= 1'b0;
                  state   <= ST_BUSY;
`ifdef INV_MIX_FWD_EN
                  mode    <= i_inverse;
`endif
               end
            end
            ST_BUSY: begin
               o_block <= next_block;
               col     <= col + 2'd1;
               if (col == 2'd3) begin
                  o_valid <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  i_ready <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: known vectors, forward-model round trips, handshake corners.
module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_valid;
   logic         i_ready;
   logic [127:0] i_block;
   logic         o_valid;
   logic         o_ready;
   logic [127:0] o_block;
`ifdef INV_MIX_FWD_EN
   logic         i_inverse;
`endif

   int           checks = 0;
   int           passed = 0;
   logic [127:0] sb [$];

   localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V2 = 128'h4d7ebdf8_d5d5d7d6_01010101_c6c6c6c6;
   localparam logic [127:0] E2 = 128'h2d26314c_d4d4d4d5_01010101_c6c6c6c6;

   always #5 clk = ~clk;

   inv_mix_columns_seq dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_block (i_block),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_block (o_block)
`ifdef INV_MIX_FWD_EN
      ,
      .i_inverse (i_inverse)
`endif
   );

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Independent forward MixColumns model; its inverse is what the DUT must compute.
   function automatic logic [7:0] tbXtime(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   function automatic logic [31:0] fwdColumn(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
      return {tbXtime(a0) ^ tbXtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ tbXtime(a1) ^ tbXtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ tbXtime(a2) ^ tbXtime(a3) ^ a3,
              tbXtime(a0) ^ a0 ^ a1 ^ a2 ^ tbXtime(a3)};
   endfunction

   function automatic logic [127:0] fwdBlock(input logic [127:0] x);
      return {fwdColumn(x[127:96]), fwdColumn(x[95:64]), fwdColumn(x[63:32]), fwdColumn(x[31:0])};
   endfunction

   // Every accepted result handshake is compared against the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && o_valid && o_ready) begin
         if (sb.size() == 0) checkOutput("sb_nonempty", 128'(sb.size()), 128'd1);
         else checkOutput("result", o_block, sb.pop_front());
      end
   end

   task automatic applyStimulus(input logic [127:0] blk, input logic [127:0] exp, input bit push);
      int n;
      n = 0;
      while (!i_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("accept_ready", 128'(i_ready), 128'd1);
      i_block = blk;
      i_valid = 1'b1;
      if (push) sb.push_back(exp);
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic waitValid(output int cycles);
      cycles = 0;
      while (!o_valid && cycles < 20) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int n;
      logic [127:0] x;
      reset   = 1'b1;
      i_valid = 1'b0;
      o_ready = 1'b1;
      i_block = '0;
`ifdef INV_MIX_FWD_EN
      i_inverse = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_i_ready", 128'(i_ready), 128'd1);
      checkOutput("rst_o_valid", 128'(o_valid), 128'd0);
      checkOutput("rst_o_block", o_block, 128'd0);
      reset = 1'b0;

      $display("[TB] known vectors");
      applyStimulus(V1, E1, 1'b1);
      waitValid(cyc);
      checkOutput("latency_v1", 128'(cyc), 128'd4);
      applyStimulus(V2, E2, 1'b1);
      waitValid(cyc);
      checkOutput("latency_v2", 128'(cyc), 128'd4);

      $display("[TB] backpressure");
      @(posedge clk); #1;
      o_ready = 1'b0;
      applyStimulus(V1, E1, 1'b1);
      waitValid(cyc);
      checkOutput("bp_latency", 128'(cyc), 128'd4);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_o_valid", 128'(o_valid), 128'd1);
         checkOutput("bp_o_block", o_block, E1);
         checkOutput("bp_i_ready", 128'(i_ready), 128'd0);
      end
      o_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("release_i_ready", 128'(i_ready), 128'd1);
      checkOutput("release_o_valid", 128'(o_valid), 128'd0);

      $display("[TB] reset mid-busy");
      applyStimulus(V2, E2, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midrst_o_valid", 128'(o_valid), 128'd0);
      checkOutput("midrst_o_block", o_block, 128'd0);
      checkOutput("midrst_i_ready", 128'(i_ready), 128'd1);
      reset = 1'b0;
      applyStimulus(V1, E1, 1'b1);
      waitValid(cyc);
      checkOutput("post_rst_latency", 128'(cyc), 128'd4);

      $display("[TB] inputs ignored while busy");
      applyStimulus(V2, E2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         i_block = {$urandom, $urandom, $urandom, $urandom};
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      waitValid(cyc);
      checkOutput("busy_o_valid", 128'(o_valid), 128'd1);

      $display("[TB] random round trips");
      for (int i = 0; i < 64; i++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(fwdBlock(x), x, 1'b1);
      end

`ifdef INV_MIX_FWD_EN
      $display("[TB] forward mode");
      i_inverse = 1'b0;
      applyStimulus(E1, V1, 1'b1);
      waitValid(cyc);
      i_inverse = 1'b1;
      applyStimulus(V1, E1, 1'b1);
`endif

      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("sb_drained", 128'(sb.size()), 128'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
